ps2_kbd_tx: RTL

// Device-side PS/2 transmitter: serialises scancode bytes onto ps2_clk/ps2_data as
// a keyboard would. Sits opposite the host PS/2 receiver; used as keyboard model in
// NPC sims and as loopback source. A small FIFO buffers bytes; host inhibit honoured.

---
 rtl/ps2_kbd_tx.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/ps2_kbd_tx.sv
// Device-side PS/2 transmitter: buffers scancode bytes in a small FIFO and
// serialises each as an 11-bit keyboard frame, backing off while the host inhibits.
module ps2_kbd_tx #(
   parameter int HALF_PERIOD = 2500,
   parameter int GAP_CYC     = 5000,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic [7:0]                    tx_data,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   input  logic                          inhibit,
   output logic                          ps2_clk,
   output logic                          ps2_data,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int CMAX = (HALF_PERIOD > GAP_CYC) ? HALF_PERIOD : GAP_CYC;
   localparam int CW   = $clog2(CMAX + 1);

   typedef enum logic [1:0] {IDLE, HIGH, LOW, GAP} state_t;

   state_t        state, state_nxt;
   logic [3:0]    bit_cnt, bit_nxt;
   logic [CW-1:0] ph, ph_nxt;
   logic [10:0]   frame, frame_nxt;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [AW:0]   count_nxt;
   logic          push, pop;
   logic          clk_d, data_d, busy_d;

   assign push = tx_valid & tx_ready;

   // state register plus registered outputs and FIFO bookkeeping
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         ph         <= '0;
         frame      <= '1;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         fifo_count <= '0;
         tx_ready   <= 1'b1;
         ps2_clk    <= 1'b1;
         ps2_data   <= 1'b1;
         busy       <= 1'b0;
      end else begin
         state      <= state_nxt;
         bit_cnt    <= bit_nxt;
         ph         <= ph_nxt;
         frame      <= frame_nxt;
         fifo_count <= count_nxt;
         tx_ready   <= (count_nxt != (AW+1)'(FIFO_DEPTH));
         ps2_clk    <= clk_d;
         ps2_data   <= data_d;
         busy       <= busy_d;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= tx_data;
   end

   always_comb begin
      count_nxt = fifo_count;
      if (push && !pop)      count_nxt = fifo_count + 1'b1;
      else if (pop && !push) count_nxt = fifo_count - 1'b1;
   end

   // next-state: an abort in HIGH leaves the FIFO untouched so the byte is resent whole
   always_comb begin
      state_nxt = state;
      bit_nxt   = bit_cnt;
      ph_nxt    = ph;
      frame_nxt = frame;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            if (fifo_count != '0 && !inhibit) begin
               state_nxt = HIGH;
               bit_nxt   = '0;
               ph_nxt    = '0;
               frame_nxt = {1'b1, ~^mem[rd_ptr], mem[rd_ptr], 1'b0};
            end
         end
         HIGH: begin
            if (inhibit && bit_cnt != 4'd10) begin
               state_nxt = GAP;
               ph_nxt    = '0;
            end else if (ph == CW'(HALF_PERIOD - 1)) begin
               state_nxt = LOW;
               ph_nxt    = '0;
            end else begin
               ph_nxt = ph + 1'b1;
            end
         end
         LOW: begin
            if (ph == CW'(HALF_PERIOD - 1)) begin
               ph_nxt = '0;
               if (bit_cnt == 4'd10) begin
                  state_nxt = GAP;
                  pop       = 1'b1;
               end else begin
                  state_nxt = HIGH;
                  bit_nxt   = bit_cnt + 1'b1;
               end
            end else begin
               ph_nxt = ph + 1'b1;
            end
         end
         GAP: begin
            if (ph == CW'(GAP_CYC - 1)) begin
               state_nxt = IDLE;
               ph_nxt    = '0;
            end else begin
               ph_nxt = ph + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // outputs are decoded from the next state so the pins are registered
   always_comb begin
      clk_d  = 1'b1;
      data_d = 1'b1;
      busy_d = (state_nxt != IDLE);
      case (state_nxt)
         HIGH: data_d = frame_nxt[bit_nxt];
         LOW: begin
            clk_d  = 1'b0;
            data_d = frame_nxt[bit_nxt];
         end
         default: ;
      endcase
   end

endmodule
